// File: rtl/smem_bank_arbiter_if.sv
// Request/response handshake and bank strobe bundle for smem_bank_arbiter.
// The slave view is the arbiter; the master view is the requester plus the banks.
interface smem_bank_arbiter_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned BANKS  = 4,
    parameter int unsigned ADDR_W = 8 + $clog2(BANKS)
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_write;
    logic [LANES-1:0]        in_mask;
    logic [LANES*ADDR_W-1:0] in_addr;
    logic [LANES*8-1:0]      in_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*8-1:0]      out_rdata;
    logic [7:0]              out_cycles;
    logic [BANKS-1:0]        bank_read;
    logic [BANKS-1:0]        bank_write;
    logic [BANKS*8-1:0]      bank_addr;
    logic [BANKS*8-1:0]      bank_wdata;
    logic [BANKS*8-1:0]      bank_rdata;

    modport master (
        output in_valid, in_write, in_mask, in_addr, in_wdata, out_ready, bank_rdata,
        input  in_ready, out_valid, out_rdata, out_cycles,
        input  bank_read, bank_write, bank_addr, bank_wdata
    );

    modport slave (
        input  in_valid, in_write, in_mask, in_addr, in_wdata, out_ready, bank_rdata,
        output in_ready, out_valid, out_rdata, out_cycles,
        output bank_read, bank_write, bank_addr, bank_wdata
    );
endinterface

// File: rtl/smem_bank_arbiter.sv
// Shared-memory bank arbiter: serialises per-bank lane conflicts of one warp access,
// drives registered bank strobes and gathers read data for a valid/ready response.
module smem_bank_arbiter #(
    parameter int unsigned LANES = 4,
    parameter int unsigned BANKS = 4
) (
    input  logic                clock,
    input  logic                reset,
    smem_bank_arbiter_if.slave  bus
);
    localparam int unsigned BB     = $clog2(BANKS);
    localparam int unsigned ADDR_W = 8 + BB;
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [1:0]              nxt_state;

    logic                    write_q;
    logic [LANES*ADDR_W-1:0] addr_q;
    logic [LANES*8-1:0]      wdata_q;
    logic [LANES-1:0]        pending_q;
    logic [BANKS-1:0]        inflight_v;
    logic [BANKS-1:0][LW-1:0] inflight_lane;

    logic                    nxt_write;
    logic [LANES*ADDR_W-1:0] nxt_addr;
    logic [LANES*8-1:0]      nxt_wdata;
    logic [LANES-1:0]        nxt_pending;
    logic [7:0]              nxt_cycles;
    logic                    clr_rdata;

    logic [LANES-1:0]        cur_grant;
    logic [LANES-1:0]        nxt_grant;
    logic [BANKS-1:0][LW-1:0] cur_lane;

    logic [BANKS-1:0]        nxt_bread;
    logic [BANKS-1:0]        nxt_bwrite;
    logic [BANKS-1:0][7:0]   nxt_baddr;
    logic [BANKS-1:0][7:0]   nxt_bwdata;

    function automatic logic [BB-1:0] lane_bank(input logic [LANES*ADDR_W-1:0] addr, input int i);
        return addr[i*ADDR_W +: BB];
    endfunction

    function automatic logic [7:0] lane_row(input logic [LANES*ADDR_W-1:0] addr, input int i);
        return addr[i*ADDR_W + BB +: 8];
    endfunction

    // Lowest pending lane per bank wins; later lanes of the same bank wait.
    function automatic logic [LANES-1:0] pick_lanes(input logic [LANES-1:0] pend,
                                                    input logic [LANES*ADDR_W-1:0] addr);
        logic [BANKS-1:0] taken;
        logic [LANES-1:0] grant;
        logic [BB-1:0]    b;
        taken = '0;
        grant = '0;
        for (int i = 0; i < LANES; i++) begin
            b = lane_bank(addr, i);
            if (pend[i] && !taken[b]) begin
                grant[i] = 1'b1;
                taken[b] = 1'b1;
            end
        end
        return grant;
    endfunction

    assign cur_grant = pick_lanes(pending_q, addr_q);

    // Bank -> lane map of the grant being issued this cycle.
    always_comb begin
        cur_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cur_grant[i]) cur_lane[lane_bank(addr_q, i)] = LW'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state   = state;
        nxt_write   = write_q;
        nxt_addr    = addr_q;
        nxt_wdata   = wdata_q;
        nxt_pending = pending_q;
        nxt_cycles  = bus.out_cycles;
        clr_rdata   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    nxt_write   = bus.in_write;
                    nxt_addr    = bus.in_addr;
                    nxt_wdata   = bus.in_wdata;
                    nxt_pending = bus.in_mask;
                    nxt_cycles  = 8'd0;
                    clr_rdata   = 1'b1;
                    nxt_state   = (bus.in_mask == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                nxt_pending = pending_q & ~cur_grant;
                nxt_cycles  = bus.out_cycles + 8'd1;
                if (nxt_pending == '0) nxt_state = S_DRAIN;
            end
            S_DRAIN: nxt_state = S_DONE;
            S_DONE:  if (bus.out_ready) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Strobes are registered, so the grant for the coming cycle is formed from next-state values.
    assign nxt_grant = (nxt_state == S_ISSUE) ? pick_lanes(nxt_pending, nxt_addr) : '0;

    always_comb begin
        nxt_bread  = '0;
        nxt_bwrite = '0;
        nxt_baddr  = '0;
        nxt_bwdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (nxt_grant[i]) begin
                nxt_bread[lane_bank(nxt_addr, i)]  = !nxt_write;
                nxt_bwrite[lane_bank(nxt_addr, i)] = nxt_write;
                nxt_baddr[lane_bank(nxt_addr, i)]  = lane_row(nxt_addr, i);
                nxt_bwdata[lane_bank(nxt_addr, i)] = nxt_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            pending_q      <= '0;
            inflight_v     <= '0;
            inflight_lane  <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_rdata  <= '0;
            bus.out_cycles <= 8'd0;
            bus.bank_read  <= '0;
            bus.bank_write <= '0;
            bus.bank_addr  <= '0;
            bus.bank_wdata <= '0;
        end else begin
            write_q        <= nxt_write;
            addr_q         <= nxt_addr;
            wdata_q        <= nxt_wdata;
            pending_q      <= nxt_pending;
            bus.out_cycles <= nxt_cycles;
            bus.in_ready   <= (nxt_state == S_IDLE);
            bus.out_valid  <= (nxt_state == S_DONE);
            bus.bank_read  <= nxt_bread;
            bus.bank_write <= nxt_bwrite;
            bus.bank_addr  <= nxt_baddr;
            bus.bank_wdata <= nxt_bwdata;
            // Reads issued this cycle return from the banks one cycle later.
            inflight_v     <= bus.bank_read;
            inflight_lane  <= cur_lane;
            if (clr_rdata) begin
                bus.out_rdata <= '0;
            end else begin
                for (int b = 0; b < BANKS; b++) begin
                    if (inflight_v[b])
                        bus.out_rdata[int'(inflight_lane[b])*8 +: 8] <= bus.bank_rdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: doc/smem_bank_arbiter.md
# smem_bank_arbiter

Request arbiter directly upstream of the shared-memory banks. It accepts one warp-wide shared-memory access (all lanes read, or all lanes write) and decodes each lane address into a bank index and row. It issues at most one lane per bank per cycle, serialising bank conflicts, and drives the banks' read/write/address/data strobes. It captures the banks' registered read data one cycle after issue and returns the gathered per-lane result through a valid/ready handshake.

## Interface
- LANES, 4: lanes per request.
- BANKS, 4: number of banks; must be a power of two. Local values: BB = log2(BANKS); ADDR_W = 8 + BB.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- in_valid  in  1  request present.
- in_ready  out  1  arbiter can accept a request; high exactly in IDLE.
- in_write  in  1  1 = all masked lanes write; 0 = all masked lanes read.
- in_mask  in  LANES  active-lane mask.
- in_addr  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W].
- in_wdata  in  LANES*8  lane i at [i*8 +: 8].
- out_valid  out  1  result ready; high exactly in DONE.
- out_ready  in  1  consumer accepts the result.
- out_rdata  out  LANES*8  gathered read data, lane i at [i*8 +: 8].
- out_cycles  out  8  issue cycles used by the last request (max lanes mapped to one bank).
- bank_read  out  BANKS  per-bank read strobe.
- bank_write  out  BANKS  per-bank write strobe.
- bank_addr  out  BANKS*8  per-bank row address.
- bank_wdata  out  BANKS*8  per-bank write data.
- bank_rdata  in  BANKS*8  per-bank registered data_out. It is valid the cycle after a read strobe.

## Operation
- Address decode: bank = addr[BB-1:0]; row = addr[ADDR_W-1:BB].
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid at an edge, latch write, mask, addr, wdata, and set pending = mask. Clear out_rdata to 0 and out_cycles to 0. Go to ISSUE, or to DONE if mask == 0.
- ISSUE: for each bank b, select the lowest-index pending lane whose bank == b.
  - Drive bank_read[b] = !write or bank_write[b] = write, with bank_addr[b] = row and bank_wdata[b] = lane data.
  - Clear the selected pending bits at the edge and increment out_cycles.
  - For reads, record the (bank -> lane) inflight map for the next cycle.
  - Go to DRAIN when pending becomes 0 at this edge.
- Capture: in any cycle following an issuing cycle, for each bank with an inflight read, write bank_rdata[b] into that lane's out_rdata slot at the edge. Inflight entries clear after capture.
- DRAIN: no bank strobes. Captures the final issue cycle's data, then go to DONE.
- DONE: out_valid=1. out_rdata and out_cycles are held stable. On out_ready, go to IDLE.
- Unselected banks: strobes are 0 and bank_addr/bank_wdata are 0.
- Same-bank conflicts serialise in ascending lane order, even at identical addresses; there is no broadcast.
  - Writes from several lanes to the same address: the highest lane is written last and wins.
- Write requests also pass through DRAIN and DONE. out_rdata stays 0 for writes and for unmasked lanes.
- Inputs are sampled only at the accepting edge; changes after acceptance are ignored.
- Bank finish signals are not used.

## Timing
- Reset (reset low, asynchronous):
  - state = IDLE; in_ready = 1.
  - out_valid, bank_read, bank_write, bank_addr, and bank_wdata are 0. Strobes drop immediately, not at the next edge.
  - out_rdata = 0, out_cycles = 0; pending and inflight are cleared.
- Reset mid-ISSUE abandons the request; no further strobes follow. Writes already issued remain in the banks.
- Latency: accept at edge E0. ISSUE occupies cycles 1..K, where K = max lanes per bank. DRAIN is cycle K+1. out_valid rises in cycle K+2.
  - Zero mask: out_valid in cycle 1.
- Throughput: a new request is accepted only in IDLE, at least one cycle after the DONE handshake. Back-to-back: out_ready at edge Ed, IDLE in the next cycle.
- out_valid held with out_ready low: everything stays frozen indefinitely.

## Test plan
- Conflict-free read, LANES=4, BANKS=4, addresses 0x004,0x009,0x00E,0x013 (banks 0,1,2,3), memory preloaded with row value = row+0x10:
  - out_cycles=1 and out_valid in cycle 3.
  - out_rdata lanes = 0x11,0x12,0x13,0x14.
- Four-way conflict: write addresses 0x000,0x004,0x008,0x00C with data AA,BB,CC,DD.
  - bank_write[0] high in cycles 1-4, rows 0,1,2,3 in order.
  - out_cycles=4; a read-back returns AA,BB,CC,DD.
- Same-address writes: all lanes write 0x005 with data 01,02,03,04.
  - Serialised in lane order; a read of 0x005 returns 04.
- Mask 4'b0000: out_valid in cycle 1, out_cycles=0, no bank strobe ever asserted.
- Mask 4'b1010 read:
  - Lanes 0 and 2 return 0x00; lanes 1 and 3 carry data.
  - Hold out_ready low for 10 cycles: outputs are stable and in_ready stays 0.
- Assert reset low mid-ISSUE of a 4-way conflict:
  - Strobes drop within the same cycle; in_ready=1 and out_rdata=0.
  - Only the writes issued before reset are visible in the bank.
